// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, exception codes and SR/Cause field positions.
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IE      = 0;
  localparam int SR_EXL     = 1;
  localparam int SR_IM_LO   = 10;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_BD     = 31;

  // EPC always holds a word address.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/cp0_req_arb.sv
// Combinational exception/interrupt arbitration for the M stage; interrupts win over exceptions.
module cp0_req_arb
  import cp0_pkg::*;
#(
  parameter int HWINT_W = 6
) (
  input  logic               reset,
  input  logic [HWINT_W-1:0] hw_int,
  input  logic [HWINT_W-1:0] im,
  input  logic               ie,
  input  logic               exl,
  input  logic [4:0]         exc_code_in,
  output logic               req,
  output logic [4:0]         exc_code
);

  logic int_req;
  logic exc_req;

  assign int_req  = (|(hw_int & im)) & ie & ~exl;
  assign exc_req  = (exc_code_in != EXC_INT) & ~exl;
  assign req      = (int_req | exc_req) & ~reset;
  assign exc_code = int_req ? EXC_INT : exc_code_in;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller at the M stage: SR/Cause/EPC/PrID, mtc0/mfc0, eret target.
// Optional BadVAddr register (reg 8) and M_BadVAddr input when CP0_BADVADDR_EN is defined.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID    = 32'h2021_0707,
  parameter int          HWINT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        M_PC,
  input  logic [4:0]         M_ExcCode,
  input  logic               M_BD,
  input  logic [HWINT_W-1:0] HWInt,
  input  logic               CP0_We,
  input  logic [4:0]         CP0_Addr,
  input  logic [31:0]        CP0_WD,
  input  logic               M_Eret,
`ifdef CP0_BADVADDR_EN
  input  logic [31:0]        M_BadVAddr,
`endif
  output logic [31:0]        CP0_RD,
  output logic [31:0]        EPC_O,
  output logic               Req
);

  logic [HWINT_W-1:0] im;
  logic               exl;
  logic               ie;
  logic               bd;
  logic [HWINT_W-1:0] ip;
  logic [4:0]         exc_code;
  logic [31:0]        epc;
  logic [4:0]         arb_code;
  logic [31:0]        pc_sel;
  logic [31:0]        sr_val;
  logic [31:0]        cause_val;
`ifdef CP0_BADVADDR_EN
  logic [31:0]        badvaddr;
`endif

  cp0_req_arb #(
    .HWINT_W(HWINT_W)
  ) u_arb (
    .reset      (reset),
    .hw_int     (HWInt),
    .im         (im),
    .ie         (ie),
    .exl        (exl),
    .exc_code_in(M_ExcCode),
    .req        (Req),
    .exc_code   (arb_code)
  );

  // A delay-slot instruction restarts at its branch.
  assign pc_sel = M_BD ? (M_PC - 32'd4) : M_PC;

  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= EXC_INT;
      epc      <= '0;
`ifdef CP0_BADVADDR_EN
      badvaddr <= '0;
`endif
    end else begin
      ip <= HWInt;
      if (Req) begin
        exl      <= 1'b1;
        bd       <= M_BD;
        exc_code <= arb_code;
        epc      <= word_align(pc_sel);
`ifdef CP0_BADVADDR_EN
        if (arb_code == EXC_ADEL || arb_code == EXC_ADES) begin
          badvaddr <= M_BadVAddr;
        end
`endif
      end else begin
        if (CP0_We) begin
          case (CP0_Addr)
            REG_SR: begin
              im  <= CP0_WD[SR_IM_LO +: HWINT_W];
              exl <= CP0_WD[SR_EXL];
              ie  <= CP0_WD[SR_IE];
            end
            REG_EPC: epc <= word_align(CP0_WD);
            default: ;
          endcase
        end
        // Placed after mtc0 so eret has the last word on EXL.
        if (M_Eret) begin
          exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    sr_val                          = '0;
    sr_val[SR_IM_LO +: HWINT_W]     = im;
    sr_val[SR_EXL]                  = exl;
    sr_val[SR_IE]                   = ie;
    cause_val                       = '0;
    cause_val[CAUSE_BD]             = bd;
    cause_val[CAUSE_IP_LO +: HWINT_W] = ip;
    cause_val[CAUSE_EXC_LO +: 5]    = exc_code;
  end

  always_comb begin
    CP0_RD = '0;
    case (CP0_Addr)
      REG_SR:       CP0_RD = sr_val;
      REG_CAUSE:    CP0_RD = cause_val;
      REG_EPC:      CP0_RD = epc;
      REG_PRID:     CP0_RD = PRID;
`ifdef CP0_BADVADDR_EN
      REG_BADVADDR: CP0_RD = badvaddr;
`endif
      default:      CP0_RD = '0;
    endcase
  end

  assign EPC_O = epc;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboard bench for cp0_exc_ctrl: directed per-cycle vectors with hand-computed expectations.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] M_PC = 32'h0000_3000;
  logic [4:0]  M_ExcCode = 5'd0;
  logic        M_BD = 1'b0;
  logic [5:0]  HWInt = 6'd0;
  logic        CP0_We = 1'b0;
  logic [4:0]  CP0_Addr = 5'd12;
  logic [31:0] CP0_WD = 32'd0;
  logic        M_Eret = 1'b0;
`ifdef CP0_BADVADDR_EN
  logic [31:0] M_BadVAddr = 32'd0;
`endif
  logic [31:0] CP0_RD;
  logic [31:0] EPC_O;
  logic        Req;

  always #5 clk = ~clk;

  cp0_exc_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .M_PC      (M_PC),
    .M_ExcCode (M_ExcCode),
    .M_BD      (M_BD),
    .HWInt     (HWInt),
    .CP0_We    (CP0_We),
    .CP0_Addr  (CP0_Addr),
    .CP0_WD    (CP0_WD),
    .M_Eret    (M_Eret),
`ifdef CP0_BADVADDR_EN
    .M_BadVAddr(M_BadVAddr),
`endif
    .CP0_RD    (CP0_RD),
    .EPC_O     (EPC_O),
    .Req       (Req)
  );

  typedef struct {
    string       nm;
    bit [2:0]    msk;
    logic        req;
    logic [31:0] rd;
    logic [31:0] epc;
  } exp_t;

  localparam bit [2:0] C_REQ = 3'b100;
  localparam bit [2:0] C_RD  = 3'b010;
  localparam bit [2:0] C_EPC = 3'b001;
  localparam bit [2:0] C_ALL = 3'b111;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: outputs are valid every cycle, so one expectation is consumed per cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.msk[2]) begin
        checks++;
        if (Req !== e.req) begin
          errors++;
          $display("FAIL %s Req got %0b expected %0b", e.nm, Req, e.req);
        end
      end
      if (e.msk[1]) begin
        checks++;
        if (CP0_RD !== e.rd) begin
          errors++;
          $display("FAIL %s CP0_RD got %08h expected %08h", e.nm, CP0_RD, e.rd);
        end
      end
      if (e.msk[0]) begin
        checks++;
        if (EPC_O !== e.epc) begin
          errors++;
          $display("FAIL %s EPC_O got %08h expected %08h", e.nm, EPC_O, e.epc);
        end
      end
    end
  end

  task automatic cyc(input string nm, input bit [2:0] msk, input logic er,
                     input logic [31:0] erd, input logic [31:0] eepc);
    exp_t e;
    e.nm = nm; e.msk = msk; e.req = er; e.rd = erd; e.epc = eepc;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic quiet();
    CP0_We = 1'b0; M_Eret = 1'b0; M_ExcCode = 5'd0; M_BD = 1'b0;
  endtask

  initial begin
    int drain;
    @(posedge clk); #1;
    // Reset holds Req low even with a pending exception.
    M_ExcCode = 5'd12; CP0_Addr = 5'd12;
    cyc("rst_state", C_ALL, 1'b0, 32'h0, 32'h0);
    reset = 1'b0; quiet();

    // Interrupt path, priority over a same-cycle exception.
    CP0_We = 1'b1; CP0_Addr = 5'd12; CP0_WD = 32'h0000_FC01;
    cyc("mtc0_sr_raw", C_ALL, 1'b0, 32'h0, 32'h0);
    quiet(); HWInt = 6'b000100; M_ExcCode = 5'd12; M_PC = 32'h0000_3000;
    cyc("int_req", C_ALL, 1'b1, 32'h0000_FC01, 32'h0);
    quiet(); HWInt = 6'd0; CP0_Addr = 5'd13;
    cyc("int_cause", C_ALL, 1'b0, 32'h0000_1000, 32'h0000_3000);
    CP0_Addr = 5'd12; M_Eret = 1'b1;
    cyc("int_exl_set", C_ALL, 1'b0, 32'h0000_FC03, 32'h0000_3000);
    quiet();
    cyc("int_eret", C_ALL, 1'b0, 32'h0000_FC01, 32'h0000_3000);

    // Delay-slot exception.
    M_ExcCode = 5'd12; M_PC = 32'h0000_3010; M_BD = 1'b1; CP0_Addr = 5'd14;
    cyc("ov_bd_req", C_ALL, 1'b1, 32'h0000_3000, 32'h0000_3000);
    quiet(); CP0_Addr = 5'd13;
    cyc("ov_bd_cause", C_ALL, 1'b0, 32'h8000_0030, 32'h0000_300C);

    // EXL masks new exceptions; eret clears EXL and keeps EPC.
    M_ExcCode = 5'd10;
    cyc("exl_mask", C_ALL, 1'b0, 32'h8000_0030, 32'h0000_300C);
    quiet(); M_Eret = 1'b1;
    cyc("exl_cause_kept", C_ALL, 1'b0, 32'h8000_0030, 32'h0000_300C);
    quiet(); CP0_Addr = 5'd12;
    cyc("eret_exl_clr", C_ALL, 1'b0, 32'h0000_FC01, 32'h0000_300C);

    // mtc0 dropped when Req fires in the same cycle.
    CP0_We = 1'b1; CP0_WD = 32'hFFFF_FFFF; M_ExcCode = 5'd4; M_PC = 32'h0000_4000;
    cyc("adel_drop_wr", C_ALL, 1'b1, 32'h0000_FC01, 32'h0000_300C);
    quiet();
    cyc("adel_sr", C_ALL, 1'b0, 32'h0000_FC03, 32'h0000_4000);
    // Same-cycle mtc0 SR (EXL=1) and eret: eret wins on EXL.
    CP0_We = 1'b1; CP0_WD = 32'h0000_FC03; M_Eret = 1'b1;
    cyc("mtc0_eret_raw", C_ALL, 1'b0, 32'h0000_FC03, 32'h0000_4000);
    quiet();
    cyc("mtc0_eret_sr", C_RD, 1'b0, 32'h0000_FC01, 32'h0);
    CP0_Addr = 5'd13;
    cyc("adel_cause", C_ALL, 1'b0, 32'h0000_0010, 32'h0000_4000);
    CP0_We = 1'b1; CP0_Addr = 5'd14; CP0_WD = 32'h0000_1237;
    cyc("mtc0_epc_raw", C_ALL, 1'b0, 32'h0000_4000, 32'h0000_4000);
    quiet();
    cyc("mtc0_epc", C_ALL, 1'b0, 32'h0000_1234, 32'h0000_1234);

    // IE=0 masks interrupts; IP still follows HWInt one cycle later.
    CP0_We = 1'b1; CP0_Addr = 5'd12; CP0_WD = 32'h0000_FC00;
    cyc("ie_off_raw", C_ALL, 1'b0, 32'h0000_FC01, 32'h0000_1234);
    quiet(); HWInt = 6'b111111;
    cyc("ie_off_req", C_ALL, 1'b0, 32'h0000_FC00, 32'h0000_1234);
    CP0_Addr = 5'd13;
    cyc("ip_all", C_ALL, 1'b0, 32'h0000_FC10, 32'h0000_1234);
    HWInt = 6'd0; CP0_Addr = 5'd15;
    cyc("prid", C_ALL, 1'b0, 32'h2021_0707, 32'h0000_1234);
    CP0_Addr = 5'd3;
    cyc("unmapped", C_RD, 1'b0, 32'h0, 32'h0);
    CP0_Addr = 5'd8;
    cyc("badvaddr_rd", C_RD, 1'b0, 32'h0, 32'h0);

    // Reset while an exception would be taken.
    CP0_We = 1'b1; CP0_Addr = 5'd12; CP0_WD = 32'h0000_FC01;
    cyc("re_en_raw", C_RD, 1'b0, 32'h0000_FC00, 32'h0);
    quiet(); M_ExcCode = 5'd12; M_PC = 32'h0000_5000;
    cyc("pre_rst_req", C_ALL, 1'b1, 32'h0000_FC01, 32'h0000_1234);
    reset = 1'b1;
    cyc("rst_mid_exc", C_REQ, 1'b0, 32'h0, 32'h0);
    reset = 1'b0; quiet();
    cyc("rst_sr", C_ALL, 1'b0, 32'h0, 32'h0);
    CP0_Addr = 5'd13;
    cyc("rst_cause", C_ALL, 1'b0, 32'h0, 32'h0);

    drain = 0;
    while (sb.size() > 0 && drain < 10) begin
      @(posedge clk); #1;
      drain++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain queue got %0d entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
